// File: rtl/x25519_seq.sv
// Upstream sequencer for the X25519 wrapper: clamps operands, loads them
// word-serially, runs the core, reads the result and hands it downstream.
module x25519_seq #(
   parameter bit          CLAMP   = 1'b1,
   parameter int unsigned RST_CYC = 2,
   parameter int unsigned TIMEOUT = 2000000
) (
   input  logic         clk,
   input  logic         i_rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [255:0] s_scalar,
   input  logic [255:0] s_point,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [255:0] m_result,
   output logic         m_zero,
   output logic         m_timeout,
   output logic         busy,
   output logic [3:0]   itf_control,
   output logic [63:0]  itf_address,
   output logic [63:0]  itf_data_in,
   input  logic [63:0]  itf_data_out,
   input  logic         itf_end_op
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_LOAD, S_CRST, S_WAIT, S_READ, S_DONE
   } state_t;

   localparam logic [31:0] RST_LAST = 32'(RST_CYC - 1);
   localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [31:0]   cnt_q, cnt_d;
   logic [255:0]  scal_q, scal_d;
   logic [255:0]  pnt_q, pnt_d;
   logic [255:0]  res_q, res_d;
   logic          to_q, to_d;
   logic          rdy_q;
   logic [3:0]    ctl_c;
   logic [2:0]    addr_c;
   logic [63:0]   din_c;

   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         scal_q  <= '0;
         pnt_q   <= '0;
         res_q   <= '0;
         to_q    <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         scal_q  <= scal_d;
         pnt_q   <= pnt_d;
         res_q   <= res_d;
         to_q    <= to_d;
         rdy_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      scal_d  = scal_q;
      pnt_d   = pnt_q;
      res_d   = res_q;
      to_d    = to_q;
      ctl_c   = 4'b0000;
      addr_c  = 3'd0;
      din_c   = 64'd0;
      unique case (state_q)
         S_IDLE: begin
            if (s_valid && rdy_q) begin
               scal_d = s_scalar;
               pnt_d  = s_point;
               if (CLAMP) begin
                  scal_d[2:0] = 3'b000;
                  scal_d[254] = 1'b1;
                  scal_d[255] = 1'b0;
                  pnt_d[255]  = 1'b0;
               end
               res_d   = '0;
               to_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_CLR;
            end
         end
         S_CLR: begin
            ctl_c   = 4'b0011;
            cnt_d   = '0;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            ctl_c  = 4'b0101;
            addr_c = cnt_q[2:0];
            din_c  = cnt_q[2] ? pnt_q[{cnt_q[1:0], 6'd0} +: 64]
                              : scal_q[{cnt_q[1:0], 6'd0} +: 64];
            if (cnt_q[2:0] == 3'd7) begin
               cnt_d   = '0;
               state_d = S_CRST;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_CRST: begin
            ctl_c = 4'b0001;
            if (cnt_q == RST_LAST) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_WAIT: begin
            // first WAIT cycle ignores end_op left over from a previous run
            if (cnt_q != 32'd0 && itf_end_op) begin
               cnt_d   = '0;
               state_d = S_READ;
            end else if (cnt_q == TO_LAST) begin
               to_d    = 1'b1;
               res_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_READ: begin
            ctl_c  = 4'b1000;
            addr_c = {1'b0, cnt_q[2:1]};
            if (cnt_q[0])
               res_d[{cnt_q[2:1], 6'd0} +: 64] = itf_data_out;
            if (cnt_q[2:0] == 3'd7) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_DONE: begin
            if (m_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign s_ready     = rdy_q && (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign m_valid     = (state_q == S_DONE);
   assign m_result    = res_q;
   assign m_timeout   = m_valid && to_q;
   assign m_zero      = m_valid && !to_q && (res_q == '0);
   assign itf_control = ctl_c;
   assign itf_address = {61'd0, addr_c};
   assign itf_data_in = din_c;

endmodule
